multi_timer_intc: RTL and testbench
===================================

// Module: multi_timer_intc
// PURPOSE
//  Memory-mapped N-channel timer plus interrupt aggregator for the single-cycle core. One free-running
//  cycle counter; each channel has a compare, a period, one-shot/periodic mode and a mask. Pending bits
//  are latched, prioritised, and one interrupt request with a channel id is presented to cp0.
//  Supersedes the single-compare timer. Sits beside data_mem on the out/B_data bus; its hit output
//  steers the load mux and gates the memory write enables.
// PARAMETERS
//  WIDTH      64             data/address/counter width
//  N_CH       4              number of timer channels, 1..8
//  BASE_ADDR  64'hFFFF0000   base of the register window
// PORTS
//  clock     in   1          sole clock, rising edge
//  reset     in   1          synchronous, active-high
//  addr      in   WIDTH      byte address from the ALU output
//  wr_data   in   WIDTH      store data (B_data)
//  we        in   1          store strobe (word_we | byte_we); byte stores are treated as full-word writes
//  rd_data   out  WIDTH      combinational read data for the addressed register; 0 when hit=0
//  hit       out  1          combinational; addr matches a defined register
//  irq       out  1          registered; |(pending & ~mask)
//  irq_id    out  3          registered; lowest index in (pending & ~mask), 0 when irq=0
//  pending   out  N_CH       registered pending vector, for debug/cp0 Cause
// BEHAVIOUR
//  Register map (offsets from BASE_ADDR; exact match on all WIDTH bits, otherwise hit=0):
//   0x1C CYCLE, read-only; writes ignored. 0x6C ACK, write-1-to-clear pending[i]; reads PENDING.
//   0x100+8i CMP_i (rw). 0x180+8i PERIOD_i (rw).
//   0x200+8i CTRL_i (rw): bit0 EN, bit1 PERIODIC, bit2 MASK (1 = suppress irq); other bits read as 0.
//  Reset: cycle=0; every CMP, PERIOD and CTRL=0; pending=0; irq=0; irq_id=0.
//  Every cycle: cycle <= cycle+1, modulo 2^WIDTH (wraps to 0).
//  Match: match_i = EN_i && (cycle == CMP_i), compared against the pre-increment cycle and the pre-write CMP_i.
//  On match_i: pending[i] <= 1 on the same edge.
//   If PERIODIC: CMP_i <= CMP_i + PERIOD_i, modulo 2^WIDTH. PERIOD=0 leaves CMP unchanged, so the channel
//   next fires after wrap.
//   If one-shot: EN_i <= 0.
//  Priority of simultaneous events:
//   - Match and ACK on the same channel in the same cycle: set wins; pending stays 1.
//   - Match and software write to CMP_i or CTRL_i: the software write wins for that register; pending is
//     still set.
//  Masking: MASK gates only irq/irq_id. pending still latches while masked, and unmasking a pending
//   channel raises irq on the next edge.
//  irq/irq_id are registered from the next-state pending and mask, so irq is high on the same edge that
//   sets pending. Latency match -> irq = 1 cycle.
//  Reset asserted mid-operation: all state returns to reset values on that edge; no match is recorded.
//  Writes with hit=0 are ignored; the top level masks data_mem writes with hit.
// STRUCTURE
//  Package mtimer_pkg holds the offset localparams (OFF_CYCLE, OFF_ACK, OFF_CMP, OFF_PERIOD, OFF_CTRL),
//  the CTRL bit positions and the channel-stride constant.
//  Sub-module timer_channel, instantiated N_CH times:
//   - holds CMP, PERIOD and CTRL; inputs cycle and the per-register write strobes; outputs match and mask.
//  Top level holds the cycle counter, address decode, read mux, pending vector and priority encoder.
// TESTING
//  1 Reset, then read CYCLE after 10 cycles -> 10 (±1 for the read cycle); all outputs 0 during reset.
//  2 CMP0=20, CTRL0=EN (one-shot) -> irq=1, irq_id=0 on the edge after cycle==20; EN0 clears; no refire.
//  3 CMP1=30, PERIOD1=10, CTRL1=EN|PERIODIC; ACK each fire -> pending[1] sets at cycles 30, 40, 50.
//  4 Channels 2 and 3 match at the same cycle -> irq_id=2; ACK 0x4 -> irq_id=3 the next cycle; ACK 0x8 -> irq=0.
//  5 CTRL0=EN|MASK, match -> pending[0]=1, irq=0; clear MASK -> irq=1 on the next edge.
//  6 ACK channel 1 on its match cycle -> pending[1] stays 1. Store to 0x1C -> CYCLE unaffected.
//    Store to an undefined offset -> hit=0.

Source files
------------

// File: rtl/mtimer_pkg.sv
// mtimer_pkg: register offsets, CTRL bit positions and channel stride for multi_timer_intc.
package mtimer_pkg;
    localparam logic [11:0] OFF_CYCLE  = 12'h01C;
    localparam logic [11:0] OFF_ACK    = 12'h06C;
    localparam logic [11:0] OFF_CMP    = 12'h100;
    localparam logic [11:0] OFF_PERIOD = 12'h180;
    localparam logic [11:0] OFF_CTRL   = 12'h200;
    localparam int CH_STRIDE    = 8;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_MASK    = 2;
    localparam int CTRL_W       = 3;
endpackage

// File: rtl/multi_timer_intc_timer_channel.sv
// timer_channel: one compare/period/ctrl channel; fires when enabled and the cycle equals CMP.
module timer_channel
    import mtimer_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WIDTH-1:0]  cycle,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              we_cmp,
    input  logic              we_period,
    input  logic              we_ctrl,
    output logic              match,
    output logic              mask_d,
    output logic [WIDTH-1:0]  cmp,
    output logic [WIDTH-1:0]  period,
    output logic [CTRL_W-1:0] ctrl
);
    logic [WIDTH-1:0]  cmp_q, cmp_d, period_q, period_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    // Software writes take precedence over the match-driven CMP advance / EN clear.
    always_comb begin
        match    = ctrl_q[CTRL_EN] && (cycle == cmp_q);
        cmp_d    = we_cmp ? wr_data : (match && ctrl_q[CTRL_PERIODIC]) ? cmp_q + period_q : cmp_q;
        period_d = we_period ? wr_data : period_q;
        ctrl_d   = we_ctrl ? wr_data[CTRL_W-1:0]
                 : (match && !ctrl_q[CTRL_PERIODIC]) ? (ctrl_q & ~(CTRL_W'(1) << CTRL_EN)) : ctrl_q;
        mask_d   = ctrl_d[CTRL_MASK];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cmp_q    <= '0;
            period_q <= '0;
            ctrl_q   <= '0;
        end else begin
            cmp_q    <= cmp_d;
            period_q <= period_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign cmp    = cmp_q;
    assign period = period_q;
    assign ctrl   = ctrl_q;
endmodule

// File: rtl/multi_timer_intc.sv
// multi_timer_intc: memory-mapped multi-channel timer with latched, prioritised interrupt output.
module multi_timer_intc
    import mtimer_pkg::*;
#(
    parameter int               WIDTH     = 64,
    parameter int               N_CH      = 4,
    parameter logic [WIDTH-1:0] BASE_ADDR = 64'hFFFF0000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             we,
    output logic [WIDTH-1:0] rd_data,
    output logic             hit,
    output logic             irq,
    output logic [2:0]       irq_id,
    output logic [N_CH-1:0]  pending
);
    logic [WIDTH-1:0]  cycle_q;
    logic [N_CH-1:0]   pending_q, pending_d, active_d, match, mask_d;
    logic [N_CH-1:0]   hit_cmp, hit_per, hit_ctrl;
    logic              hit_cyc, hit_ack, irq_q;
    logic [2:0]        irq_id_q, irq_id_d;
    logic [WIDTH-1:0]  cmp_rd [N_CH];
    logic [WIDTH-1:0]  per_rd [N_CH];
    logic [CTRL_W-1:0] ctrl_rd [N_CH];

    always_comb begin
        hit_cyc = addr == BASE_ADDR + WIDTH'(OFF_CYCLE);
        hit_ack = addr == BASE_ADDR + WIDTH'(OFF_ACK);
        for (int i = 0; i < N_CH; i++) begin
            hit_cmp[i]  = addr == BASE_ADDR + WIDTH'(OFF_CMP) + WIDTH'(i * CH_STRIDE);
            hit_per[i]  = addr == BASE_ADDR + WIDTH'(OFF_PERIOD) + WIDTH'(i * CH_STRIDE);
            hit_ctrl[i] = addr == BASE_ADDR + WIDTH'(OFF_CTRL) + WIDTH'(i * CH_STRIDE);
        end
        hit     = hit_cyc | hit_ack | (|hit_cmp) | (|hit_per) | (|hit_ctrl);
        rd_data = hit_cyc ? cycle_q : hit_ack ? WIDTH'(pending_q) : '0;
        for (int i = 0; i < N_CH; i++) begin
            if (hit_cmp[i])  rd_data = cmp_rd[i];
            if (hit_per[i])  rd_data = per_rd[i];
            if (hit_ctrl[i]) rd_data = WIDTH'(ctrl_rd[i]);
        end
        // A match on the same edge as an ACK keeps the pending bit set.
        pending_d = (pending_q & ~((we && hit_ack) ? wr_data[N_CH-1:0] : '0)) | match;
        active_d  = pending_d & ~mask_d;
        irq_id_d  = '0;
        for (int i = N_CH - 1; i >= 0; i--)
            if (active_d[i]) irq_id_d = 3'(i);
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        timer_channel #(.WIDTH(WIDTH)) u_ch (
            .clock     (clock),
            .reset     (reset),
            .cycle     (cycle_q),
            .wr_data   (wr_data),
            .we_cmp    (we && hit_cmp[c]),
            .we_period (we && hit_per[c]),
            .we_ctrl   (we && hit_ctrl[c]),
            .match     (match[c]),
            .mask_d    (mask_d[c]),
            .cmp       (cmp_rd[c]),
            .period    (per_rd[c]),
            .ctrl      (ctrl_rd[c])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q   <= '0;
            pending_q <= '0;
            irq_q     <= 1'b0;
            irq_id_q  <= '0;
        end else begin
            cycle_q   <= cycle_q + 1'b1;
            pending_q <= pending_d;
            irq_q     <= |active_d;
            irq_id_q  <= irq_id_d;
        end
    end

    assign irq     = irq_q;
    assign irq_id  = irq_id_q;
    assign pending = pending_q;
endmodule

// File: tb/tb_multi_timer_intc.sv
// tb_multi_timer_intc: directed plus random stimulus checked against a behavioural timer model.
module tb_multi_timer_intc;
    localparam int          N    = 4;
    localparam logic [63:0] BASE = 64'hFFFF0000;

    logic        clock = 1'b0, reset = 1'b1, we = 1'b0, hit, irq;
    logic [63:0] addr = '0, wr_data = '0, rd_data;
    logic [2:0]  irq_id;
    logic [N-1:0] pending;

    logic [63:0] m_cyc = '0, m_cmp [N], m_per [N];
    logic        m_en [N], m_pdc [N], m_msk [N];
    logic [N-1:0] m_pend = '0;
    logic        m_irq = 1'b0;
    logic [2:0]  m_id = '0;
    logic        last_hit;
    logic [63:0] last_rd;
    int checks = 0, errors = 0;

    multi_timer_intc dut (
        .clock(clock), .reset(reset), .addr(addr), .wr_data(wr_data), .we(we),
        .rd_data(rd_data), .hit(hit), .irq(irq), .irq_id(irq_id), .pending(pending)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, m_cyc);
        end
    endtask

    task automatic model_read(input logic [63:0] a, output logic h, output logic [63:0] d);
        logic [63:0] off;
        off = a - BASE;
        h = 1'b0;
        d = '0;
        if (off == 64'h1C) begin h = 1'b1; d = m_cyc; end
        if (off == 64'h6C) begin h = 1'b1; d = 64'(m_pend); end
        for (int i = 0; i < N; i++) begin
            if (off == 64'h100 + 64'(8 * i)) begin h = 1'b1; d = m_cmp[i]; end
            if (off == 64'h180 + 64'(8 * i)) begin h = 1'b1; d = m_per[i]; end
            if (off == 64'h200 + 64'(8 * i)) begin h = 1'b1; d = 64'({m_msk[i], m_pdc[i], m_en[i]}); end
        end
    endtask

    task automatic model_edge(input logic [63:0] a, input logic [63:0] d, input logic w, input logic r);
        logic [N-1:0] fired;
        logic [63:0] off;
        off = a - BASE;
        if (r) begin
            m_cyc = '0;
            m_pend = '0;
            for (int i = 0; i < N; i++) begin
                m_cmp[i] = '0; m_per[i] = '0; m_en[i] = 0; m_pdc[i] = 0; m_msk[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) fired[i] = m_en[i] && (m_cyc == m_cmp[i]);
            if (w && off == 64'h6C) m_pend = m_pend & ~d[N-1:0];
            m_pend = m_pend | fired;
            for (int i = 0; i < N; i++) begin
                if (fired[i]) begin
                    if (m_pdc[i]) m_cmp[i] = m_cmp[i] + m_per[i];
                    else m_en[i] = 1'b0;
                end
                if (w && off == 64'h100 + 64'(8 * i)) m_cmp[i] = d;
                if (w && off == 64'h180 + 64'(8 * i)) m_per[i] = d;
                if (w && off == 64'h200 + 64'(8 * i)) begin
                    m_en[i] = d[0]; m_pdc[i] = d[1]; m_msk[i] = d[2];
                end
            end
            m_cyc = m_cyc + 1;
        end
        m_irq = 1'b0;
        m_id  = '0;
        for (int i = 0; i < N; i++)
            if (!m_irq && m_pend[i] && !m_msk[i]) begin m_irq = 1'b1; m_id = 3'(i); end
    endtask

    task automatic step(input logic [63:0] a, input logic [63:0] d, input logic w);
        logic eh;
        logic [63:0] ed;
        addr = a; wr_data = d; we = w;
        @(negedge clock);
        model_read(a, eh, ed);
        last_hit = hit;
        last_rd  = rd_data;
        check("hit", 64'(hit), 64'(eh));
        check("rd_data", rd_data, ed);
        @(posedge clock);
        model_edge(a, d, w, reset);
        #1;
        check("irq", 64'(irq), 64'(m_irq));
        check("irq_id", 64'(irq_id), 64'(m_id));
        check("pending", 64'(pending), 64'(m_pend));
    endtask

    task automatic wr(input logic [11:0] off, input logic [63:0] d);
        step(BASE + 64'(off), d, 1'b1);
    endtask

    task automatic rd(input logic [11:0] off);
        step(BASE + 64'(off), '0, 1'b0);
    endtask

    task automatic idle_until(input logic [63:0] c);
        for (int k = 0; k < 200 && m_cyc < c; k++) step('0, '0, 1'b0);
    endtask

    initial begin
        logic [63:0] t;
        for (int i = 0; i < N; i++) begin
            m_cmp[i] = '0; m_per[i] = '0; m_en[i] = 0; m_pdc[i] = 0; m_msk[i] = 0;
        end
        // Reset: outputs all zero while held.
        repeat (3) step('0, '0, 1'b0);
        check("rst_irq", 64'(irq), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        reset = 1'b0;
        idle_until(10);
        rd(12'h01C);
        check("cycle_10", last_rd, 64'd10);

        // One-shot channel 0.
        wr(12'h100, 64'd20);
        wr(12'h200, 64'd1);
        idle_until(21);
        check("oneshot_irq", 64'(irq), 64'd1);
        check("oneshot_id", 64'(irq_id), 64'd0);
        rd(12'h200);
        check("oneshot_en_clr", last_rd, 64'd0);
        wr(12'h06C, 64'h1);
        idle_until(40);
        check("oneshot_norefire", 64'(pending[0]), 64'd0);

        // Periodic channel 1 with ACK after each fire.
        t = m_cyc + 10;
        wr(12'h108, t);
        wr(12'h188, 64'd10);
        wr(12'h208, 64'd3);
        for (int f = 0; f < 3; f++) begin
            idle_until(t + 64'(10 * f) + 1);
            check("periodic_fire", 64'(pending[1]), 64'd1);
            wr(12'h06C, 64'h2);
        end
        wr(12'h208, 64'd0);

        // Simultaneous channels 2 and 3.
        t = m_cyc + 6;
        wr(12'h110, t); wr(12'h118, t); wr(12'h210, 64'd1); wr(12'h218, 64'd1);
        idle_until(t + 1);
        check("prio_id2", 64'(irq_id), 64'd2);
        wr(12'h06C, 64'h4);
        check("prio_id3", 64'(irq_id), 64'd3);
        wr(12'h06C, 64'h8);
        check("prio_clear", 64'(irq), 64'd0);

        // Masked channel 0, then unmask.
        t = m_cyc + 5;
        wr(12'h100, t);
        wr(12'h200, 64'd5);
        idle_until(t + 1);
        check("mask_pending", 64'(pending[0]), 64'd1);
        check("mask_irq", 64'(irq), 64'd0);
        wr(12'h200, 64'd0);
        check("unmask_irq", 64'(irq), 64'd1);
        wr(12'h06C, 64'h1);

        // ACK on the match cycle: set wins.
        t = m_cyc + 5;
        wr(12'h108, t);
        wr(12'h208, 64'd1);
        idle_until(t);
        wr(12'h06C, 64'h2);
        check("ack_vs_match", 64'(pending[1]), 64'd1);
        wr(12'h06C, 64'h2);
        t = m_cyc;
        wr(12'h01C, 64'd12345);
        rd(12'h01C);
        check("cycle_ro", last_rd, t + 1);
        step(BASE + 64'h20, 64'd5, 1'b1);
        check("undef_hit", 64'(last_hit), 64'd0);
        step((BASE | (64'd1 << 40)) + 64'h1C, '0, 1'b0);
        check("hi_bit_miss", 64'(last_hit), 64'd0);

        // Periodic CMP advance wraps modulo 2^64.
        t = m_cyc + 5;
        wr(12'h110, t);
        wr(12'h190, 64'hFFFF_FFFF_FFFF_FFFB);
        wr(12'h210, 64'd3);
        idle_until(t + 1);
        rd(12'h110);
        check("cmp_wrap", last_rd, t - 5);
        wr(12'h210, 64'd0);
        wr(12'h06C, 64'hF);

        // Reset on a match edge records nothing.
        t = m_cyc + 4;
        wr(12'h118, t);
        wr(12'h218, 64'd1);
        idle_until(t);
        reset = 1'b1;
        step('0, '0, 1'b0);
        check("rst_nomatch", 64'(pending), 64'd0);
        reset = 1'b0;

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            int unsigned op, ch;
            op = $urandom_range(0, 11);
            ch = $urandom_range(0, N - 1);
            reset = ($urandom_range(0, 299) == 0);
            case (op)
                0, 1: wr(12'(12'h100 + 8 * ch), m_cyc + 64'($urandom_range(0, 20)));
                2:    wr(12'(12'h180 + 8 * ch), 64'($urandom_range(0, 12)));
                3:    wr(12'(12'h200 + 8 * ch), 64'($urandom_range(0, 15)));
                4:    wr(12'h06C, 64'($urandom_range(0, 15)));
                5:    rd(12'($urandom_range(0, 2) * 12'h080 + 12'h100 + 8 * ch));
                6:    step(BASE + 64'($urandom_range(0, 12'hFFF)), 64'($urandom), 1'b1);
                7:    rd(($urandom_range(0, 1) == 0) ? 12'h01C : 12'h06C);
                default: step('0, '0, 1'b0);
            endcase
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
